// File: rtl/cfg_loader_pkg.sv
// Shared definitions for the SelfWrite bitstream loader: state encoding,
// fetch length and the byte-packing order.
package cfg_loader_pkg;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_SETUP  = 3'd2;
  localparam logic [2:0] ST_STROBE = 3'd3;
  localparam logic [2:0] ST_HOLD   = 3'd4;
  localparam logic [2:0] ST_SETTLE = 3'd5;
  localparam logic [2:0] ST_URST   = 3'd6;
  localparam logic [2:0] ST_DONE   = 3'd7;

  localparam int FETCH_CYC = 5;
  localparam int DLY_W     = 32;
  localparam bit BYTE_BIG_ENDIAN = 1'b1;

  // Shift one image byte into the word being assembled.
  function automatic logic [31:0] pack_byte(input logic [31:0] word, input logic [7:0] b);
    return BYTE_BIG_ENDIAN ? {word[23:0], b} : {b, word[31:8]};
  endfunction
endpackage

// File: rtl/cfg_delay_counter.sv
// Loadable down-counter with zero flag; stops at zero until reloaded.
module cfg_delay_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_zero
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_cnt <= '0;
    else if (i_load)         r_cnt <= i_val;
    else if (r_cnt != '0)    r_cnt <= r_cnt - 1'b1;
  end

  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/cfg_bitstream_sequencer.sv
// Loads a byte-wide image from synchronous memory, packs 4 bytes per word and
// drives the SelfWrite port with fixed setup/hold, then pulses user reset.
module cfg_bitstream_sequencer
  import cfg_loader_pkg::*;
#(
  parameter int ADDR_W     = 14,
  parameter int SETUP_CYC  = 2,
  parameter int HOLD_CYC   = 2,
  parameter int SETTLE_CYC = 100,
  parameter int URST_CYC   = 5
) (
  input  logic              CLK,
  input  logic              resetn,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   byte_count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [7:0]        mem_rdata,
  output logic [31:0]       SelfWriteData,
  output logic              SelfWriteStrobe,
  output logic              user_reset,
  output logic              busy,
  output logic              done
);
  localparam logic [ADDR_W:0] MAX_BYTES  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [2:0]      FETCH_LAST = 3'(FETCH_CYC - 1);

  logic [2:0]        r_state, w_nxt;
  logic [2:0]        r_fcnt;
  logic [ADDR_W-3:0] r_word;
  logic [ADDR_W:0]   r_bcnt;
  logic              r_rd_vld;
  logic [31:0]       r_pack, r_swd;

  logic [ADDR_W:0]   w_baddr, w_next_base;
  logic              w_rd_en, w_start_ok, w_zero, w_load;
  logic [7:0]        w_byte;
  logic [DLY_W-1:0]  w_load_val;

  assign w_baddr     = {1'b0, r_word, r_fcnt[1:0]};
  assign w_next_base = {1'b0, r_word, 2'b00} + (ADDR_W+1)'(4);
  assign w_rd_en     = (r_state == ST_FETCH) && (r_fcnt < 3'd4) && (w_baddr < r_bcnt);
  // Bytes beyond the image were never read, so they pack as zero.
  assign w_byte      = r_rd_vld ? mem_rdata : 8'h00;
  assign w_start_ok  = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start && !abort;
  assign w_load      = (w_nxt != r_state);

  cfg_delay_counter #(.W(DLY_W)) u_dly (
    .clk    (CLK),
    .rst_n  (resetn),
    .i_load (w_load),
    .i_val  (w_load_val),
    .o_zero (w_zero)
  );

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (start) w_nxt = (byte_count == '0) ? ST_SETTLE : ST_FETCH;
      ST_FETCH:  if (r_fcnt == FETCH_LAST) w_nxt = ST_SETUP;
      ST_SETUP:  if (w_zero) w_nxt = ST_STROBE;
      ST_STROBE: w_nxt = ST_HOLD;
      ST_HOLD:   if (w_zero) w_nxt = (w_next_base >= r_bcnt) ? ST_SETTLE : ST_FETCH;
      ST_SETTLE: if (w_zero) w_nxt = ST_URST;
      ST_URST:   if (w_zero) w_nxt = ST_DONE;
      default:   w_nxt = ST_IDLE;
    endcase
    if (abort) w_nxt = ST_IDLE;
  end

  always_comb begin
    w_load_val = '0;
    case (w_nxt)
      ST_SETUP:  w_load_val = DLY_W'(SETUP_CYC - 1);
      ST_HOLD:   w_load_val = DLY_W'(HOLD_CYC - 1);
      ST_SETTLE: w_load_val = DLY_W'(SETTLE_CYC - 1);
      ST_URST:   w_load_val = DLY_W'(URST_CYC - 1);
      default:   w_load_val = '0;
    endcase
  end

  always_comb begin
    mem_rd_en       = w_rd_en;
    mem_addr        = w_rd_en ? w_baddr[ADDR_W-1:0] : '0;
    SelfWriteData   = r_swd;
    SelfWriteStrobe = (r_state == ST_STROBE);
    user_reset      = (r_state == ST_URST);
    busy            = (r_state != ST_IDLE) && (r_state != ST_DONE);
    done            = (r_state == ST_DONE);
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_fcnt   <= '0;
      r_word   <= '0;
      r_bcnt   <= '0;
      r_rd_vld <= 1'b0;
      r_pack   <= '0;
      r_swd    <= '0;
    end else begin
      r_rd_vld <= w_rd_en;
      r_fcnt   <= (r_state == ST_FETCH && w_nxt == ST_FETCH) ? r_fcnt + 3'd1 : 3'd0;
      if (w_start_ok) begin
        r_bcnt <= (byte_count > MAX_BYTES) ? MAX_BYTES : byte_count;
        r_word <= '0;
      end else if (r_state == ST_HOLD && w_nxt == ST_FETCH) begin
        r_word <= r_word + 1'b1;
      end
      if (r_state == ST_FETCH && r_fcnt != 3'd0) r_pack <= pack_byte(r_pack, w_byte);
      if (r_state == ST_FETCH && w_nxt == ST_SETUP) r_swd <= pack_byte(r_pack, w_byte);
    end
  end
endmodule

// File: tb/tb_cfg_bitstream_sequencer.sv
// Bench for the SelfWrite loader: directed table, abort/reset corners, random loads.
`timescale 1ns/1ps
module tb_cfg_bitstream_sequencer;
  localparam int ADDR_W = 14;
  localparam int MEMSZ  = 1 << ADDR_W;

  logic              CLK = 1'b0, resetn = 1'b0, start = 1'b0, abort = 1'b0;
  logic [ADDR_W:0]   byte_count = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [7:0]        mem_rdata = 8'h00;
  logic [31:0]       SelfWriteData;
  logic              SelfWriteStrobe, user_reset, busy, done;

  always #5 CLK = ~CLK;

  cfg_bitstream_sequencer dut (
    .CLK(CLK), .resetn(resetn), .start(start), .abort(abort), .byte_count(byte_count),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .SelfWriteData(SelfWriteData), .SelfWriteStrobe(SelfWriteStrobe),
    .user_reset(user_reset), .busy(busy), .done(done)
  );

  logic [7:0] mem [0:MEMSZ-1];
  always @(posedge CLK) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Event log, append-only; tests look at the part added since they began.
  logic [31:0] st_data[$];
  int st_cyc[$], u_cyc[$], d_cyc[$], rd_addr[$];
  logic done_q = 1'b0;
  always @(negedge CLK) begin
    if (SelfWriteStrobe) begin st_data.push_back(SelfWriteData); st_cyc.push_back(cyc); end
    if (user_reset) u_cyc.push_back(cyc);
    if (done && !done_q) d_cyc.push_back(cyc);
    done_q = done;
    if (mem_rd_en) rd_addr.push_back(int'(mem_addr));
  end

  int checks = 0, failures = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input int n, input int w);
    logic [31:0] r = 0;
    for (int k = 0; k < 4; k++) r = (r << 8) | ((4*w + k < n) ? 32'(mem[4*w + k]) : 32'h0);
    return r;
  endfunction

  task automatic pulse_start(input int bc, output int c0);
    @(posedge CLK); #1;
    start = 1'b1; byte_count = (ADDR_W+1)'(bc); c0 = cyc;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic run_load(input int bc, input string tag,
                          output logic [31:0] w0, output logic [31:0] wl, output int nw);
    int n, words, c0, sb, ub, db, rb, bad, lim, i, exp_urst, ucnt, ufirst, dfirst;
    n = (bc > MEMSZ) ? MEMSZ : bc;
    words = (n + 3) / 4;
    sb = st_data.size(); ub = u_cyc.size(); db = d_cyc.size(); rb = rd_addr.size();
    pulse_start(bc, c0);
    lim = words * 10 + 300; i = 0;
    while (!done && i < lim) begin @(negedge CLK); i++; end
    check({tag, "_done_reached"}, done, 1'b1);
    @(negedge CLK);
    nw = st_data.size() - sb;
    check({tag, "_n_strobes"}, nw, words);
    bad = -1;
    for (int k = 0; k < nw && k < words; k++)
      if (bad < 0 && st_data[sb+k] !== model_word(n, k)) bad = k;
    check({tag, "_first_bad_word"}, bad, -1);
    bad = 0;
    for (int k = 0; k < nw; k++) if (st_cyc[sb+k] != c0 + 8 + 10*k) bad++;
    check({tag, "_strobe_timing_errs"}, bad, 0);
    exp_urst = (words > 0) ? c0 + 8 + 10*(words-1) + 103 : c0 + 101;
    ucnt   = u_cyc.size() - ub;
    ufirst = (ucnt > 0) ? u_cyc[ub] : -1;
    dfirst = (d_cyc.size() > db) ? d_cyc[db] : -1;
    check({tag, "_urst_start"}, ufirst, exp_urst);
    check({tag, "_urst_len"}, ucnt, 5);
    check({tag, "_done_cycle"}, dfirst, exp_urst + 5);
    bad = 0;
    for (int k = 0; k < rd_addr.size() - rb; k++) if (rd_addr[rb+k] != k || k >= n) bad++;
    check({tag, "_reads"}, rd_addr.size() - rb, n);
    check({tag, "_bad_reads"}, bad, 0);
    w0 = (nw > 0) ? st_data[sb] : 32'h0;
    wl = (nw > 0) ? st_data[st_data.size()-1] : 32'h0;
  endtask

  typedef struct {
    int bc; logic [7:0] base; logic [7:0] step;
    int exp_words; logic [31:0] exp_w0; logic [31:0] exp_wl;
  } vec_t;
  vec_t vt[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w0, wl;
    int nw, c0, sb, rb, seen, bc;
    vt[0] = '{8,     8'h01, 8'h01, 2,    32'h01020304, 32'h05060708};
    vt[1] = '{6,     8'hAA, 8'h11, 2,    32'hAABBCCDD, 32'hEEFF0000};
    vt[2] = '{0,     8'h00, 8'h01, 0,    32'h0,        32'h0};
    vt[3] = '{1,     8'h10, 8'h01, 1,    32'h10000000, 32'h10000000};
    vt[4] = '{7,     8'hF0, 8'h01, 2,    32'hF0F1F2F3, 32'hF4F5F600};
    vt[5] = '{4,     8'h40, 8'h01, 1,    32'h40414243, 32'h40414243};
    vt[6] = '{16390, 8'h00, 8'h01, 4096, 32'h00010203, 32'hFCFDFEFF};

    #23;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_strobe", SelfWriteStrobe, 0);
    check("rst_urst", user_reset, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_data", SelfWriteData, 0);
    @(negedge CLK); resetn = 1'b1;

    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < MEMSZ; i++) mem[i] = 8'(vt[v].base + vt[v].step * i);
      run_load(vt[v].bc, $sformatf("vec%0d", v), w0, wl, nw);
      check($sformatf("vec%0d_words", v), nw, vt[v].exp_words);
      if (vt[v].exp_words > 0) begin
        check($sformatf("vec%0d_w0", v), w0, vt[v].exp_w0);
        check($sformatf("vec%0d_wlast", v), wl, vt[v].exp_wl);
      end
    end

    // Abort on the strobe of the second word.
    for (int i = 0; i < MEMSZ; i++) mem[i] = 8'(1 + i);
    sb = st_data.size();
    pulse_start(8, c0);
    seen = 0;
    for (int i = 0; i < 100 && seen < 2; i++) begin
      @(negedge CLK);
      if (SelfWriteStrobe) seen++;
    end
    check("abort_strobe_seen", seen, 2);
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_strobe", SelfWriteStrobe, 0);
    check("abort_rd_en", mem_rd_en, 0);
    check("abort_data_hold", SelfWriteData, 32'h05060708);
    repeat (20) @(negedge CLK);
    check("abort_stays_idle", busy, 0);
    check("abort_strobes_total", st_data.size() - sb, 2);
    run_load(8, "restart", w0, wl, nw);
    check("restart_wlast", wl, 32'h05060708);

    // abort and start together from DONE
    @(negedge CLK);
    start = 1'b1; abort = 1'b1;
    @(negedge CLK);
    start = 1'b0; abort = 1'b0;
    check("abort_beats_start_busy", busy, 0);
    check("abort_beats_start_done", done, 0);

    // start while busy is ignored; reset in SETTLE clears everything.
    sb = st_data.size(); rb = rd_addr.size();
    pulse_start(8, c0);
    repeat (2) @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 100 && seen < 2; i++) begin
      @(negedge CLK);
      if (SelfWriteStrobe) seen++;
    end
    repeat (20) @(negedge CLK);
    check("busy_start_strobes", st_data.size() - sb, 2);
    check("busy_start_t2", (st_data.size() - sb == 2) ? st_cyc[sb+1] : -1, c0 + 18);
    check("busy_start_reads", rd_addr.size() - rb, 8);
    check("settle_busy", busy, 1);
    check("settle_urst", user_reset, 0);
    #2; resetn = 1'b0; #1;
    check("rstmid_busy", busy, 0);
    check("rstmid_data", SelfWriteData, 0);
    check("rstmid_strobe", SelfWriteStrobe, 0);
    check("rstmid_done", done, 0);
    @(negedge CLK); resetn = 1'b1;
    sb = st_data.size();
    repeat (150) @(negedge CLK);
    check("post_rst_idle", busy, 0);
    check("post_rst_no_urst", user_reset | done, 0);
    check("post_rst_no_strobe", st_data.size() - sb, 0);

    for (int r = 0; r < 15; r++) begin
      bc = $urandom_range(0, 64);
      for (int i = 0; i < 80; i++) mem[i] = 8'($urandom);
      run_load(bc, $sformatf("rnd%0d", r), w0, wl, nw);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
